// File: rtl/io_debouncer_pkg.sv
// Shared constants for the io_debouncer block: FSM state encoding and glitch-counter width.
package io_debouncer_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/io_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; reusable by other lib/io blocks.
module io_sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_in};
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/io_debouncer.sv
// Synchronizer plus stability filter for a raw pin; o_level only flips after STABLE_CYCLES agreeing samples.
// Optional IO_DEBOUNCER_GLITCH_COUNT_EN adds a saturating count of rejected glitches (o_glitch_cnt).
//
// state      | meaning
// ST_STABLE  | o_level matches the synchronized input, nothing being qualified
// ST_PENDING | a different level has been seen; counting consecutive agreeing samples
module io_debouncer
    import io_debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_level,
    output logic o_busy
`ifdef IO_DEBOUNCER_GLITCH_COUNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
`endif
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic               level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               w_sync;

    io_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_in    (i_in),
        .o_sync  (w_sync)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_STABLE;
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_STABLE: begin
                if (w_sync != level_q) begin
                    // A one-sample window needs no qualification phase
                    if (STABLE_CYCLES == 1) begin
                        level_d = w_sync;
                    end else begin
                        state_d = ST_PENDING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_PENDING: begin
                if (w_sync == level_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = w_sync;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    assign o_level = level_q;
    assign o_busy  = (state_q == ST_PENDING);

`ifdef IO_DEBOUNCER_GLITCH_COUNT_EN
    logic [GLITCH_CNT_W-1:0] glitch_q;
    logic                    reject;

    assign reject = (state_q == ST_PENDING) && (w_sync == level_q);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            glitch_q <= '0;
        end else if (reject && (glitch_q != {GLITCH_CNT_W{1'b1}})) begin
            glitch_q <= glitch_q + GLITCH_CNT_W'(1);
        end
    end

    assign o_glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_io_debouncer.sv
// Directed bench for io_debouncer: window-based reference model checked every cycle plus literal timing checks.
module tb_io_debouncer;

    localparam int S = 2;
    localparam int N = 4;

    logic clk;
    logic rst;
    logic in;
    logic in_r1;
    logic o_level, o_busy;
    logic o_level_r1, o_busy_r1;
`ifdef IO_DEBOUNCER_GLITCH_COUNT_EN
    logic [7:0] gcnt;
    logic [7:0] gcnt_r1;
`endif

    int n_vec;
    int n_err;

    io_debouncer #(
        .SYNC_STAGES   (S),
        .STABLE_CYCLES (N),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_in    (in),
        .o_level (o_level),
        .o_busy  (o_busy)
`ifdef IO_DEBOUNCER_GLITCH_COUNT_EN
        ,
        .o_glitch_cnt (gcnt)
`endif
    );

    io_debouncer #(
        .SYNC_STAGES   (S),
        .STABLE_CYCLES (N),
        .RESET_LEVEL   (1'b1)
    ) dut_r1 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_in    (in_r1),
        .o_level (o_level_r1),
        .o_busy  (o_busy_r1)
`ifdef IO_DEBOUNCER_GLITCH_COUNT_EN
        ,
        .o_glitch_cnt (gcnt_r1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: hist[j] is the raw input sampled j edges ago; the filter sees hist[S].
    // The level flips once the newest N visible samples all disagree with it.
    logic hist [S+N];
    logic m_level;
    logic m_busy;
    int   m_gcnt;
    logic m_all_diff;
    logic m_prev_level;
    logic m_prev_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < S + N; i++) hist[i] = 1'b0;
            m_level = 1'b0;
            m_busy  = 1'b0;
            m_gcnt  = 0;
        end else begin
            m_prev_level = m_level;
            m_prev_busy  = m_busy;
            for (int i = S + N - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = in;
            m_all_diff = 1'b1;
            for (int j = S; j < S + N; j++) if (hist[j] == m_level) m_all_diff = 1'b0;
            if (m_all_diff) m_level = ~m_level;
            m_busy = (hist[S] != m_level);
            if (m_prev_busy && !m_busy && (m_level == m_prev_level) && (m_gcnt < 255)) m_gcnt++;
        end
    end

    // Every-cycle compare plus a downstream falling-edge detector on o_level.
    int   fall_pulses;
    logic prev_lvl;

    always @(negedge clk) begin
        check("model_level", o_level, m_level);
        check("model_busy", o_busy, m_busy);
`ifdef IO_DEBOUNCER_GLITCH_COUNT_EN
        check("model_glitch_cnt", gcnt, m_gcnt);
`endif
        check("r1_level", o_level_r1, 1);
        check("r1_busy", o_busy_r1, 0);
        if (prev_lvl && !o_level) fall_pulses++;
        prev_lvl = o_level;
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        fall_pulses = 0;
        prev_lvl = 1'b0;
        rst   = 1'b1;
        in    = 1'b0;
        in_r1 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_level", o_level, 0);
        check("reset_busy", o_busy, 0);
        check("reset_level_r1", o_level_r1, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean rise: level after edge 6, busy after edges 3..5
        in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            check("rise_level", o_level, (e >= 6) ? 1 : 0);
            check("rise_busy", o_busy, (e >= 3 && e <= 5) ? 1 : 0);
        end
        in = 1'b0;
        repeat (10) @(negedge clk);
        check("fall_settled", o_level, 0);

        // Glitch: three high samples are one short of the window
        in = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            check("glitch_level", o_level, 0);
            check("glitch_busy", o_busy, (e >= 3 && e <= 5) ? 1 : 0);
            if (e == 3) in = 1'b0;
        end
`ifdef IO_DEBOUNCER_GLITCH_COUNT_EN
        check("glitch_cnt_one", gcnt, 1);
`endif

        // Boundary accept: exactly four high samples, then fall six edges after input drops
        in = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            check("bound_level", o_level, (e >= 6 && e <= 9) ? 1 : 0);
            check("bound_busy", o_busy, (e inside {3, 4, 5, 7, 8, 9}) ? 1 : 0);
            if (e == 4) in = 1'b0;
        end

        // Async reset while qualifying
        repeat (4) @(negedge clk);
        in = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_before_reset", o_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_busy", o_busy, 0);
        check("async_reset_level", o_level, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            check("requal_level", o_level, (e >= 6) ? 1 : 0);
            check("requal_busy", o_busy, (e >= 3 && e <= 5) ? 1 : 0);
        end

        // Toggle every clock never qualifies
        in = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_toggle_level", o_level, 0);
        for (int e = 1; e <= 12; e++) begin
            in = ~in;
            @(negedge clk);
            check("toggle1_level", o_level, 0);
        end
        in = 1'b0;
        repeat (4) @(negedge clk);

        // Toggle every two clocks, then one long high and a single downstream fall pulse
        fall_pulses = 0;
        for (int t = 1; t <= 10; t++) begin
            in = ~in;
            repeat (2) @(negedge clk);
            check("toggle2_level", o_level, 0);
        end
        check("toggle2_falls", fall_pulses, 0);
        in = 1'b1;
        repeat (20) @(negedge clk);
        check("long_high_level", o_level, 1);
        check("long_high_falls", fall_pulses, 0);
        in = 1'b0;
        repeat (20) @(negedge clk);
        check("final_level", o_level, 0);
        check("final_falls", fall_pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
